uart_rx_mmio: RTL and testbench
===============================

# uart_rx_mmio

Memory-mapped UART receive port on the peripheral side of the CPU's MM/IO split. It deserialises the `rx` line with 16x oversampling and buffers received bytes in a small FIFO. It presents either the FIFO head or a status byte on `data_out`, which the top-level MM/IO multiplexer routes to the datapath whenever bus A bit 12 selects IO space. It runs on the undivided board clock; CPU accesses arrive as multi-cycle `rd` levels from the microinstruction word.

## Interface
- `CLK_FREQ`, 50000000, board clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `FIFO_DEPTH`, 8, RX FIFO entries; must be a power of 2, minimum 2
- `clk`  input  1  board clock, undivided
- `rst`  input  1  reset, asynchronous and active-low
- `rx`  input  1  serial line, asynchronous to `clk`, idles high
- `rd`  input  1  CPU read strobe (microword read bit), level, may span many `clk` cycles
- `s_mmio`  input  1  IO-space select (bus A bit 12)
- `s_io`  input  1  register select (bus A bit 0): 0 = data, 1 = status
- `data_out`  output  8  FIFO head or status byte
- `rx_ready`  output  1  FIFO not empty

## Operation
- `rx` passes through a 2-flop synchroniser with reset value 1. Edge detection uses the synchronised value only.
- Oversample tick: the divisor is CLK_FREQ/(16*BAUD), truncated. A free-running counter produces a 1-cycle tick at that rate.
- RX FSM states:
  - IDLE: on a synchronised falling edge, clear the tick count and go to START.
  - START: at tick 7, if the line is still 0, go to DATA; otherwise treat it as a glitch and return to IDLE with no flags set.
  - DATA: sample 8 bits LSB-first, one every 16 ticks, at bit centre.
  - PARITY: present only with the macro; see Configuration.
  - STOP: sample at centre. A 1 pushes the byte. A 0 discards the byte, sets sticky `ferr`, and the FSM waits for the line to return to 1 before going to IDLE.
- FIFO push when full: the byte is dropped, sticky `ovr` is set and the contents are unchanged. The exception is a pop in the same cycle; then both take effect.
- Access qualifier: `acc = rd & s_mmio`.
- `data_out` is combinational from registered state:
  - `s_io = 0`: FIFO head, or 0x00 when the FIFO is empty.
  - `s_io = 1`: status byte {3'b0, `perr`, `ovr`, `ferr`, full, not_empty}.
- Side effects happen on the falling edge of `acc` (registered `acc` is 1 and current `acc` is 0). This keeps the data stable for the whole microcycle.
  - Data access (`s_io = 0`, value held from the last cycle of `acc`): pop one entry if not empty. A pop on empty does nothing.
  - Status access: clear `ferr`, `ovr` and `perr`. An error raised in the same cycle as the clear wins, and the flag stays set.
- A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - `data_out` = 0x00 for either select.
  - `rx_ready` = 0.
  - FSM in IDLE; FIFO pointers, count and sticky flags all 0.
- Reset asserted mid-frame aborts the frame; nothing is pushed. After release, the FSM needs a fresh falling edge to start.
- Latency from the stop-bit centre sample to `rx_ready`/head valid: 1 `clk`. The synchroniser adds 2 `clk` before that.
- Pop and flag clear take effect 1 `clk` after `acc` falls. The next read sees the new head.
- Nominal frame length is 160 ticks, and STOP exits at the stop-bit centre, so back-to-back frames are accepted with no idle bit.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state between DATA and STOP samples one even-parity bit.
  - On mismatch the byte is still pushed and sticky `perr` (status bit 4) is set.
  - Frame is 11 bits.
- Undefined:
  - No PARITY state; frame is 10 bits (8N1).
  - `perr` is tied to 0.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding;
  - status bit index constants (READY = 0, FULL = 1, FERR = 2, OVR = 3, PERR = 4);
  - a divisor function of CLK_FREQ and BAUD.
- One sub-module `rx_fifo`: synchronous FIFO with push/pop, full/empty, count and a combinational head. The FSM, synchroniser, tick generator and bus logic live in the top module.

## Test plan
Defaults apply unless stated: divisor 27, bit = 432 `clk`.
- Single byte: send 0xA5 8N1, wait 1000 `clk` -> `rx_ready` = 1; status read gives 0x01; data read gives 0xA5; after `acc` falls, `rx_ready` = 0 and the next data read gives 0x00.
- Glitch: drive `rx` low for 100 `clk`, then high -> FSM returns to IDLE, status stays 0x00 and nothing is pushed.
- Framing: send 0x3C with stop bit 0 -> status reads 0x04 and the FIFO stays empty; a second status read gives 0x00.
- Overrun: send 9 bytes 0x01..0x09 with no reads -> status 0x0B; 8 data reads return 0x01..0x08, then status 0x08.
- Simultaneous: with FIFO full (8 entries), let a data-read `acc` fall in the same cycle as a stop-bit push of 0x55 -> count stays 8, `ovr` stays 0, and 0x55 is the last entry.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 (correct value 1) -> byte 0x07 is pushed and status reads 0x11; with correct parity, status reads 0x01.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive port: FSM encoding, status bit
// positions and the oversample divisor helper.
package uart_pkg;

  // Receiver FSM states. StParity is only reachable when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  // Bit positions inside the status byte.
  localparam int unsigned StatReady = 0;
  localparam int unsigned StatFull  = 1;
  localparam int unsigned StatFerr  = 2;
  localparam int unsigned StatOvr   = 3;
  localparam int unsigned StatPerr  = 4;

  // Clock cycles per 16x oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / (16 * baud);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO for the UART receiver. A push while full is dropped
// unless a pop happens in the same cycle; a pop while empty is ignored.
module rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: 16x oversampled deserialiser feeding a byte
// FIFO, read through a data/status register pair. Side effects (pop, flag
// clear) fire when the CPU access level falls, so data stays stable for the
// whole microcycle. Define UART_RX_PARITY_EN to add an even-parity bit (8E1).
module uart_rx_mmio #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  input  logic       s_mmio,
  input  logic       s_io,
  output logic [7:0] data_out,
  output logic       rx_ready
);

  import uart_pkg::*;

  localparam int unsigned Div    = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(Div - 1);

  // Synchroniser and edge detect.
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;

  // Tick generator.
  logic [DivW-1:0] div_q;
  logic            tick;

  // Receiver FSM.
  rx_state_e   state_q, state_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        centre;
  logic        push;
  logic        set_ferr;

  // Bus side.
  logic acc, acc_q, sel_q, acc_fall, pop, clr;

  // FIFO and flags.
  logic [7:0] head;
  logic       full, empty;
  logic       set_ovr;
  logic       ferr_q, ovr_q;
  logic       perr;
  logic [7:0] status;

  // Two-flop synchroniser; also keep the previous synced value for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // Free-running oversample divider producing a one-cycle tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (div_q == DivMax) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick   = (div_q == DivMax);
  // Bit centre: 16 ticks after the previous sample point.
  assign centre = tick && (tick_cnt_q == 4'd15);

  // Receiver FSM state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic set_perr;
  logic perr_q;
`endif

  // Receiver FSM next state and frame-level strobes.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    set_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_perr   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_fall) begin
          tick_cnt_d = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            // Half a bit in: a start bit must still be low, else it was a glitch.
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_s2_q ? StIdle : StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (centre) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s2_q, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (centre) begin
          tick_cnt_d = '0;
          set_perr   = (rx_s2_q != ^shift_q);
          state_d    = StStop;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end
`endif
      StStop: begin
        if (centre) begin
          tick_cnt_d = '0;
          // Leave at the stop-bit centre so a back-to-back start edge is caught.
          if (rx_s2_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            set_ferr = 1'b1;
            state_d  = StBreak;
          end
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end
      StBreak: begin
        // Framing error: hold off until the line is idle again.
        if (rx_s2_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign acc      = rd & s_mmio;
  assign acc_fall = acc_q & ~acc;
  assign pop      = acc_fall & ~sel_q;
  assign clr      = acc_fall & sel_q;

  // Access edge tracking; the register select is latched while the access is live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      acc_q <= acc;
      if (acc) sel_q <= s_io;
    end
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (shift_q),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Overrun only when the push is actually dropped.
  assign set_ovr = push & full & ~(pop & ~empty);

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= set_ferr | (ferr_q & ~clr);
      ovr_q  <= set_ovr | (ovr_q & ~clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= set_perr | (perr_q & ~clr);
    end
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  // Status byte assembly and register select for the read port.
  always_comb begin
    status            = '0;
    status[StatReady] = ~empty;
    status[StatFull]  = full;
    status[StatFerr]  = ferr_q;
    status[StatOvr]   = ovr_q;
    status[StatPerr]  = perr;
    if (s_io) begin
      data_out = status;
    end else begin
      data_out = empty ? 8'h00 : head;
    end
  end

  assign rx_ready = ~empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed self-checking bench for uart_rx_mmio. Received bytes are queued on
// a scoreboard as frames are sent and popped when data reads return them.
module tb_uart_rx_mmio;

  localparam int unsigned ClkFreq = 16000000;
  localparam int unsigned Baud    = 115200;
  localparam int unsigned Depth   = 8;
  // 16e6 / (16 * 115200) = 8.68, truncated to 8.
  localparam int unsigned Div     = 8;
  localparam int unsigned Bit     = Div * 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       s_mmio = 1'b0;
  logic       s_io = 1'b0;
  logic [7:0] data_out;
  logic       rx_ready;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] sb [$];
  logic [7:0] v;
  logic [7:0] e;
  logic       found;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_mmio #(
    .CLK_FREQ   (ClkFreq),
    .BAUD       (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd       (rd),
    .s_mmio   (s_mmio),
    .s_io     (s_io),
    .data_out (data_out),
    .rx_ready (rx_ready)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Bit) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (Bit) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (Bit) @(negedge clk);
    rx = 1'b1;
  endtask

  // Full bus access: value sampled mid-access, side effect when rd drops.
  task automatic bus_read(input logic sel, output logic [7:0] val);
    @(negedge clk);
    s_mmio = 1'b1;
    s_io   = sel;
    rd     = 1'b1;
    repeat (3) @(negedge clk);
    val    = data_out;
    rd     = 1'b0;
    s_mmio = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Look at the status byte without an access, so nothing is cleared.
  task automatic peek_status(output logic [7:0] val);
    @(negedge clk);
    s_io = 1'b1;
    @(negedge clk);
    val  = data_out;
    s_io = 1'b0;
  endtask

  task automatic read_expect(input string tag);
    logic [7:0] rv;
    logic [7:0] ev;
    bus_read(1'b0, rv);
    ev = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    check(tag, rv, ev);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 8'h00);
    s_io = 1'b1;
    #1;
    check("rst_status", data_out, 8'h00);
    check("rst_ready", {7'b0, rx_ready}, 8'h00);
    s_io = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("single_ready", {7'b0, rx_ready}, 8'h01);
    bus_read(1'b1, v);
    check("single_status", v, 8'h01);
    read_expect("single_data");
    check("single_ready_after", {7'b0, rx_ready}, 8'h00);
    bus_read(1'b0, v);
    check("single_empty_data", v, 8'h00);

    // Glitch shorter than half a bit
    @(negedge clk);
    rx = 1'b0;
    repeat (Bit / 4) @(negedge clk);
    rx = 1'b1;
    repeat (Bit * 12) @(negedge clk);
    peek_status(v);
    check("glitch_status", v, 8'h00);
    check("glitch_ready", {7'b0, rx_ready}, 8'h00);

    // Framing error
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    bus_read(1'b1, v);
    check("ferr_status", v, 8'h04);
    check("ferr_ready", {7'b0, rx_ready}, 8'h00);
    bus_read(1'b1, v);
    check("ferr_status2", v, 8'h00);

    // Overrun: nine back-to-back bytes, the ninth is dropped
    for (int b = 1; b <= 9; b++) begin
      if (b <= 8) sb.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    repeat (20) @(negedge clk);
    peek_status(v);
    check("ovr_status", v, 8'h0B);
    for (int i = 0; i < 8; i++) read_expect($sformatf("ovr_data%0d", i));
    bus_read(1'b1, v);
    check("ovr_status_after", v, 8'h08);

    // Simultaneous pop and push while full
    for (int b = 1; b <= 8; b++) begin
      sb.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    repeat (20) @(negedge clk);
    @(negedge clk);
    s_mmio = 1'b1;
    s_io   = 1'b0;
    rd     = 1'b1;
    found  = 1'b0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int i = 0; i < int'(Bit * 12); i++) begin
          @(negedge clk);
          if (dut.push) begin
            found = 1'b1;
            break;
          end
        end
        e = sb.pop_front();
        check("sim_head", data_out, e);
        rd     = 1'b0;
        s_mmio = 1'b0;
      end
    join
    sb.push_back(8'h55);
    check("sim_push_seen", {7'b0, found}, 8'h01);
    repeat (20) @(negedge clk);
    peek_status(v);
    check("sim_status", v, 8'h03);
    for (int i = 0; i < 8; i++) read_expect($sformatf("sim_data%0d", i));
    check("sim_ready_after", {7'b0, rx_ready}, 8'h00);

`ifdef UART_RX_PARITY_EN
    // Parity: bad parity still pushes, good parity leaves perr clear
    par_flip = 1'b1;
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(1'b1, v);
    check("perr_status", v, 8'h11);
    read_expect("perr_data");
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge clk);
    bus_read(1'b1, v);
    check("par_ok_status", v, 8'h01);
    read_expect("par_ok_data");
`endif

    // Reset mid-frame aborts it
    @(negedge clk);
    rx = 1'b0;
    repeat (Bit * 3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (Bit * 12) @(negedge clk);
    check("midrst_ready", {7'b0, rx_ready}, 8'h00);
    peek_status(v);
    check("midrst_status", v, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
